calc_operand_entry: RTL
=======================

// Module: calc_operand_entry
// PURPOSE
//  Front-end entry stage that feeds the 4-bit calculator core.
//  Debounces the ENTER and CLEAR pushbuttons, then captures operand A, operand B
//  and the opcode from the shared slide switches over three presses.
//  Presents the captured triple to the core with a valid/ready handshake.
//  Exports the entry-step number so the board LEDs can show the current step.
// PARAMETERS
//  DATA_W          4   operand width (a, b, sw_data)
//  OP_W            2   opcode width
//  DEBOUNCE_CYCLES 16  consecutive stable synchronized cycles needed to accept a
//                      button level change; legal range >= 2
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous, active-low reset
//  sw_data    in   DATA_W  operand switches; user holds them steady across a press
//  sw_op      in   OP_W    opcode switches
//  btn_enter  in   1       raw ENTER button, asynchronous, bouncy, active high
//  btn_clear  in   1       raw CLEAR button, asynchronous, bouncy, active high
//  a_out      out  DATA_W  captured operand A
//  b_out      out  DATA_W  captured operand B
//  op_out     out  OP_W    captured opcode
//  valid      out  1       a_out/b_out/op_out form a complete request
//  ready      in   1       core accepts the request; tied to 1 when the core is always enabled
//  step       out  2       current entry step: 0=A, 1=B, 2=OP, 3=ISSUE
// BEHAVIOUR
//  Reset (rst_n=0, async, no clock needed)
//   - all outputs 0, state GET_A
//   - sync flops, debounced levels and debounce counters cleared to 0
//  Input synchronizer
//   - each button passes through 2 flops before any other logic uses it
//  Debounce, per button
//   - the counter increments while the synced level differs from the debounced level
//   - the counter resets to 0 on any cycle where the two levels match
//   - the debounced level flips on the edge at which the counter would reach DEBOUNCE_CYCLES
//  Press event
//   - a 1-cycle registered pulse on each 0->1 transition of the debounced level
//   - the event asserts exactly 2+DEBOUNCE_CYCLES+1 edges after the raw level becomes stably high
//   - a button held through reset release produces one press
//  FSM (step = encoding)
//   - GET_A : enter press -> a_out<=sw_data, go to GET_B
//   - GET_B : enter press -> b_out<=sw_data, go to GET_OP
//   - GET_OP: enter press -> op_out<=sw_op, valid<=1, go to ISSUE
//   - ISSUE : valid=1; on a cycle with valid&&ready -> valid<=0, go to GET_A
//   - ISSUE : enter presses are ignored
//  Capture rule
//   - each capture samples the switches on the edge where the press pulse is high
//  Output stability
//   - a_out, b_out and op_out stay stable while valid=1
//   - after the handshake they hold until overwritten by the next capture
//  Clear press (any state)
//   - next state GET_A, valid<=0, a_out/b_out/op_out<=0
//   - clear wins over an enter press or a handshake in the same cycle
//  Asynchronous reset mid-operation aborts the sequence; valid drops with no clock edge
//  Outputs carry no arithmetic; widths pass through unchanged
// TESTING (DEBOUNCE_CYCLES=4, ready=1 unless stated)
//  - sw=3 enter; sw=5 enter; sw_op=01 enter -> valid=1 for 1 cycle with a=3,b=5,op=01; then step=0
//  - enter high 3 cycles then low -> step unchanged; enter high 6 cycles -> step 0->1, exactly 1 press
//  - enter toggles every cycle for 20 cycles, then stays high -> exactly one step advance
//  - ready=0 in ISSUE for 10 cycles, plus 2 enter presses -> valid held, outputs and step=3 stable;
//    ready=1 -> handshake, step=0
//  - step=2, clear and enter pressed together -> step=0, outputs 0, valid never asserts
//  - rst_n=0 between edges while valid=1 -> valid=0 and step=0 immediately; all outputs 0

Source files
------------

// File: rtl/calc_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : calc_operand_entry
//  Purpose  : Entry stage for the 4-bit calculator core. Synchronizes and
//             debounces the ENTER and CLEAR buttons, captures operand A,
//             operand B and the opcode over three ENTER presses, and offers
//             the captured triple to the core through a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module calc_operand_entry #(
  parameter int DATA_W          = 4,
  parameter int OP_W            = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   sw_op,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic              valid,
  input  logic              ready,
  output logic [1:0]        step
);

  // The counter only ever needs to hold DEBOUNCE_CYCLES-1; the level flips
  // on the edge where it would otherwise reach DEBOUNCE_CYCLES.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       enter_press;
  logic       clear_press;

  // Bit 0 is ENTER, bit 1 is CLEAR; both buttons share the same conditioning.
  assign btn_raw = {btn_clear, btn_enter};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic             deb;
      logic             deb_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt;

      // Two-flop synchronizer, stability counter, debounced level and a
      // one-cycle pulse on each rising edge of the debounced level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1   <= 1'b0;
          sync2   <= 1'b0;
          deb     <= 1'b0;
          deb_q   <= 1'b0;
          press_q <= 1'b0;
          cnt     <= '0;
        end else begin
          sync1 <= btn_raw[i];
          sync2 <= sync1;
          if (sync2 != deb) begin
            if (cnt == CNT_LAST) begin
              deb <= sync2;
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
          deb_q   <= deb;
          press_q <= deb & ~deb_q;
        end
      end

      assign press[i] = press_q;
    end
  endgenerate

  assign enter_press = press[0];
  assign clear_press = press[1];

  // Entry sequencer: captures A, B, OP on successive ENTER presses, then holds
  // the request until the core takes it. CLEAR overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= GET_A;
      a_out  <= '0;
      b_out  <= '0;
      op_out <= '0;
      valid  <= 1'b0;
    end else if (clear_press) begin
      state  <= GET_A;
      a_out  <= '0;
      b_out  <= '0;
      op_out <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (enter_press) begin
            a_out <= sw_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (enter_press) begin
            b_out <= sw_data;
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (enter_press) begin
            op_out <= sw_op;
            valid  <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // ENTER is ignored here so the request cannot change under the core.
          if (valid && ready) begin
            valid <= 1'b0;
            state <= GET_A;
          end
        end
        default: begin
          state <= GET_A;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // The step indicator is the state register itself.
  assign step = state;

endmodule
`default_nettype wire
